// File: rtl/mp_add_sequencer_if.sv
// Request/response bundle for mp_add_sequencer.
// Carries ovf_o only when MP_ADD_SIGNED_OVF_EN is defined.
interface mp_add_sequencer_if #(
  parameter int NUM_LIMBS = 4
);
  localparam int W = 64 * NUM_LIMBS;

  logic         req_valid_i;
  logic         req_ready_o;
  logic         sub_i;
  logic         carry_i;
  logic [W-1:0] op1_i;
  logic [W-1:0] op2_i;
  logic         resp_valid_o;
  logic         resp_ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         busy_o;
`ifdef MP_ADD_SIGNED_OVF_EN
  logic         ovf_o;
`endif

  modport master (
`ifdef MP_ADD_SIGNED_OVF_EN
    input  ovf_o,
`endif
    output req_valid_i, sub_i, carry_i, op1_i, op2_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, sum_o, carry_o, busy_o
  );

  modport slave (
`ifdef MP_ADD_SIGNED_OVF_EN
    output ovf_o,
`endif
    input  req_valid_i, sub_i, carry_i, op1_i, op2_i, resp_ready_i,
    output req_ready_o, resp_valid_o, sum_o, carry_o, busy_o
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one limb per cycle through a shared 64-bit Brent-Kung adder.
// Define MP_ADD_SIGNED_OVF_EN to add the signed-overflow flag ovf_o.
module mp_add_bk64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  logic [63:0] gen;
  logic [63:0] prop;
  logic [63:0] grp_g;
  logic [63:0] grp_p;

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  always_comb begin
    gen      = a & b;
    prop     = a ^ b;
    grp_g    = gen;
    grp_p    = prop;
    grp_g[0] = gen[0] | (prop[0] & cin);
    for (int lvl = 0; lvl < 6; lvl++) begin
      for (int i = (2 << lvl) - 1; i < 64; i += (2 << lvl)) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
        grp_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
      end
    end
    for (int lvl = 4; lvl >= 0; lvl--) begin
      for (int i = (3 << lvl) - 1; i < 64; i += (2 << lvl)) begin
        grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i - (1 << lvl)]);
        grp_p[i] = grp_p[i] & grp_p[i - (1 << lvl)];
      end
    end
    sum  = prop ^ {grp_g[62:0], cin};
    cout = grp_g[63];
  end
endmodule

module mp_add_sequencer #(
  parameter int NUM_LIMBS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  mp_add_sequencer_if.slave   bus
);
  localparam int W     = 64 * NUM_LIMBS;
  localparam int CNT_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] limb_cnt;
  logic [W-1:0]     op1_q;
  logic [W-1:0]     op2_q;
  logic             sub_q;
  logic             carry_q;
  logic [W-1:0]     sum_q;
  logic             carry_out_q;
  logic [CNT_W+5:0] limb_base;
  logic [63:0]      op_a;
  logic [63:0]      op_b;
  logic [63:0]      add_sum;
  logic             add_cout;
  logic             last_limb;

  assign limb_base = {limb_cnt, 6'd0};
  assign op_a      = op1_q[limb_base +: 64];
  assign op_b      = sub_q ? ~op2_q[limb_base +: 64] : op2_q[limb_base +: 64];
  assign last_limb = (limb_cnt == CNT_W'(NUM_LIMBS - 1));

  mp_add_bk64 u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MP_ADD_SIGNED_OVF_EN
  logic ovf_q;
  logic carry_in_msb;

  // Carry into bit 63 recovered from the sum bit; XOR with carry out gives signed overflow.
  assign carry_in_msb = add_sum[63] ^ op_a[63] ^ op_b[63];
  assign bus.ovf_o    = ovf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && bus.req_valid_i) begin
      ovf_q <= 1'b0;
    end else if (state == RUN && last_limb) begin
      ovf_q <= carry_in_msb ^ add_cout;
    end
  end
`endif

  // Subtraction runs as op1 + ~op2 + ~borrow, so carry and borrow are complements at both ends.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      limb_cnt    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            op1_q    <= bus.op1_i;
            op2_q    <= bus.op2_i;
            sub_q    <= bus.sub_i;
            carry_q  <= bus.carry_i ^ bus.sub_i;
            limb_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q[limb_base +: 64] <= add_sum;
          carry_q                <= add_cout;
          if (last_limb) begin
            carry_out_q <= add_cout ^ sub_q;
            state       <= DONE;
          end else begin
            limb_cnt <= limb_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.resp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o  = (state == IDLE);
  assign bus.resp_valid_o = (state == DONE);
  assign bus.busy_o       = (state != IDLE);
  assign bus.sum_o        = sum_q;
  assign bus.carry_o      = carry_out_q;
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
- Multi-precision add/subtract controller built around one 64-bit Brent-Kung adder instance.
- Accepts a NUM_LIMBS×64-bit operand pair over a valid/ready request channel.
- Issues one 64-bit limb per cycle, least significant limb first, and chains each limb's carry into the next.
- Returns the full-width result on a valid/ready response channel. Used by the crypto/bignum path wherever operands exceed 64 bits.

Parameters:
- NUM_LIMBS, 4, number of 64-bit limbs per operand (≥1); total width W = 64*NUM_LIMBS

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request ready (high only in IDLE)
- sub_i  input  1  0: op1+op2+cin; 1: op1−op2−bin
- carry_i  input  1  carry-in (add) / borrow-in (sub)
- op1_i  input  W  operand 1, unsigned
- op2_i  input  W  operand 2, unsigned
- resp_valid_o  output  1  result valid
- resp_ready_i  input  1  result accepted
- sum_o  output  W  result
- carry_o  output  1  carry-out (add) / borrow-out (sub)
- busy_o  output  1  high in RUN or DONE

Behaviour:
- FSM states are IDLE, RUN, DONE. Reset puts the FSM in IDLE with limb counter 0. Reset values: sum_o=0, carry_o=0, resp_valid_o=0, busy_o=0; req_ready_o=1 after reset.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch op1_i, op2_i and sub_i.
  - The internal carry register is set to carry_i for add and ~carry_i for sub.
  - Limb counter k is set to 0. Next state is RUN.
- RUN (one cycle per limb k = 0..NUM_LIMBS−1):
  - Adder inputs: a = op1[k], b = sub ? ~op2[k] : op2[k], cin = carry register.
  - sum_o[k] and the carry register are registered at the end of the cycle.
  - After limb NUM_LIMBS−1, carry_o is set to sub ? ~cout : cout. Next state is DONE.
- DONE:
  - resp_valid_o=1. sum_o and carry_o are held stable until resp_ready_i.
  - On resp_ready_i, resp_valid_o drops and the FSM returns to IDLE; req_ready_o is 1 on the following cycle.
  - A new request cannot be accepted in the same cycle as the response handshake.
- Latency: request accepted at edge t; resp_valid_o rises after edge t+NUM_LIMBS. Throughput is one op per NUM_LIMBS+2 cycles minimum.
- Limbs of sum_o not yet written in RUN hold their previous-operation values; they are valid only when resp_valid_o=1.
- With NUM_LIMBS=1, RUN lasts exactly one cycle.
- Arithmetic is modulo 2^W.
  - Add: carry_o=1 iff op1+op2+cin ≥ 2^W.
  - Sub: carry_o=1 iff op1 < op2+bin.
- Inputs other than resp_ready_i are ignored outside IDLE. req_valid_i during RUN/DONE is not accepted and not queued.
- Asserting rst_ni low at any point, including mid-RUN or in DONE with resp_valid_o=1, immediately aborts the operation, forces all outputs to reset values and discards partial results.

Optional Feature:
- Macro MP_ADD_SIGNED_OVF_EN.
- Defined:
  - Adds output port ovf_o (1 bit, reset 0), valid with resp_valid_o.
  - Signals two's-complement overflow of the W-bit result: carry into bit W−1 XOR carry out of bit W−1, computed on the final limb.
  - Held with sum_o and cleared when a new request is accepted.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- NUM_LIMBS=4, add, op1=2^64−1 (limb0 all ones, others 0), op2=1, carry_i=0 → sum_o=2^64 (limb1=1, rest 0), carry_o=0, resp_valid_o exactly 4 cycles after accept.
- Add, op1=op2=2^256−1, carry_i=1 → sum_o=2^256−1, carry_o=1. Verifies the ripple across all limbs.
- Sub, op1=0, op2=1, carry_i=0 → sum_o=2^256−1, carry_o=1 (borrow). Sub, op1=5, op2=3 → sum_o=2, carry_o=0.
- Backpressure: hold resp_ready_i=0 for 10 cycles in DONE while toggling req_valid_i → sum_o/carry_o stable, req_ready_o=0, no accept. Release → IDLE next cycle, then accept.
- Deassert rst_ni during RUN limb 2 → resp_valid_o=0, sum_o=0, req_ready_o=1 after release. The next op (3+4) returns 7 with correct latency.
- With MP_ADD_SIGNED_OVF_EN: op1=2^255−1, op2=1 add → ovf_o=1; op1=−1 (all ones), op2=1 → ovf_o=0, carry_o=1.
